// File: rtl/hazard_sched_unit.sv
// hazard_sched_unit: hazard detection, forwarding selects, branch flush and
// flag register for the 5-stage LEGv8 pipeline. The unit tracks its own
// shadow copy of the destination info held in ID/EX, EX/MEM and MEM/WB.
module hazard_sched_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_rn_used,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_rb_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_read_mem,
  input  logic             id_set_flags,
  input  logic             id_cbz,
  input  logic             id_br_taken,
  input  logic             ex_n,
  input  logic             ex_z,
  input  logic             ex_v,
  input  logic             ex_c,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       cbz_fwd,
  output logic             cond_n,
  output logic             cond_z,
  output logic             cond_v,
  output logic             cond_c,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b01;
  localparam logic [1:0] SEL_MEMWB   = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             read_mem;
    logic             set_flags;
  } stage_t;

  localparam stage_t EMPTY_STAGE = '{valid: 1'b0, rd: '0, reg_write: 1'b0,
                                     read_mem: 1'b0, set_flags: 1'b0};

  stage_t ex_stage, mem_stage, wb_stage;
  stage_t ex_next;

  logic       load_use_stall;
  logic       cbz_stall;
  logic       stall;
  logic [1:0] fwd_a_next, fwd_b_next;

  // A stage supplies register r only if it really writes a non-XZR register.
  function automatic logic stage_match(input stage_t s,
                                       input logic [REG_W-1:0] r,
                                       input logic used);
    return s.valid && s.reg_write && (s.rd == r) && (r != ZERO_IDX) && used;
  endfunction

  // Operand select for an EX operand: the closest producer wins.
  function automatic logic [1:0] ex_select(input stage_t ex_s,
                                           input stage_t mem_s,
                                           input logic [REG_W-1:0] r,
                                           input logic used);
    if (stage_match(ex_s, r, used))
      return SEL_EXMEM;
    else if (stage_match(mem_s, r, used))
      return SEL_MEMWB;
    else
      return SEL_REGFILE;
  endfunction

  // Stall detection, CBZ operand select and the instruction entering EX.
  always_comb begin
    load_use_stall = 1'b0;
    cbz_stall      = 1'b0;
    cbz_fwd        = SEL_REGFILE;
    ex_next        = EMPTY_STAGE;
    fwd_a_next     = SEL_REGFILE;
    fwd_b_next     = SEL_REGFILE;

    load_use_stall = id_valid && ex_stage.read_mem &&
                     (stage_match(ex_stage, id_rn, id_rn_used) ||
                      stage_match(ex_stage, id_rb, id_rb_used));

    // CBZ resolves in ID, so an EX producer or a load still in MEM is too late.
    cbz_stall = id_cbz &&
                (stage_match(ex_stage, id_rb, 1'b1) ||
                 (mem_stage.read_mem && stage_match(mem_stage, id_rb, 1'b1)));

    if (stage_match(mem_stage, id_rb, 1'b1) && !mem_stage.read_mem)
      cbz_fwd = SEL_EXMEM;
    else if (stage_match(wb_stage, id_rb, 1'b1))
      cbz_fwd = SEL_MEMWB;

    if (id_valid && !(load_use_stall || cbz_stall)) begin
      ex_next.valid     = 1'b1;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write && (id_rd != ZERO_IDX);
      ex_next.read_mem  = id_read_mem;
      ex_next.set_flags = id_set_flags;
      fwd_a_next        = ex_select(ex_stage, mem_stage, id_rn, id_rn_used);
      fwd_b_next        = ex_select(ex_stage, mem_stage, id_rb, id_rb_used);
    end
  end

  assign stall       = load_use_stall || cbz_stall;
  assign pc_en       = !stall;
  assign ifid_en     = !stall;
  assign idex_bubble = stall;
  assign ifid_flush  = id_valid && id_br_taken && !stall;

  // Flags from an ADDS/SUBS in EX are bypassed so B.LT can follow directly.
  always_comb begin
    cond_n = flag_n;
    cond_z = flag_z;
    cond_v = flag_v;
    cond_c = flag_c;
    if (ex_stage.valid && ex_stage.set_flags) begin
      cond_n = ex_n;
      cond_z = ex_z;
      cond_v = ex_v;
      cond_c = ex_c;
    end
  end

  // Shadow pipeline advance and registered EX forwarding selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_stage  <= EMPTY_STAGE;
      mem_stage <= EMPTY_STAGE;
      wb_stage  <= EMPTY_STAGE;
      fwd_a     <= SEL_REGFILE;
      fwd_b     <= SEL_REGFILE;
    end else begin
      ex_stage  <= ex_next;
      mem_stage <= ex_stage;
      wb_stage  <= mem_stage;
      fwd_a     <= fwd_a_next;
      fwd_b     <= fwd_b_next;
    end
  end

  // Architectural flag register, written by flag-setting instructions in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_c <= 1'b0;
    end else if (ex_stage.valid && ex_stage.set_flags) begin
      flag_n <= ex_n;
      flag_z <= ex_z;
      flag_v <= ex_v;
      flag_c <= ex_c;
    end
  end

endmodule

// File: tb/tb_hazard_sched_unit.sv
// tb_hazard_sched_unit: directed instruction sequences with hand-computed
// expected hazard, forwarding and flag outputs.
module tb_hazard_sched_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn;
  logic       id_rn_used;
  logic [4:0] id_rb;
  logic       id_rb_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_read_mem;
  logic       id_set_flags;
  logic       id_cbz;
  logic       id_br_taken;
  logic       ex_n, ex_z, ex_v, ex_c;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b, cbz_fwd;
  logic       cond_n, cond_z, cond_v, cond_c;
  logic       flag_n, flag_z, flag_v, flag_c;

  int total_checks = 0;
  int bad_checks   = 0;

  hazard_sched_unit #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rb(id_rb), .id_rb_used(id_rb_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_read_mem(id_read_mem),
    .id_set_flags(id_set_flags), .id_cbz(id_cbz), .id_br_taken(id_br_taken),
    .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .cbz_fwd(cbz_fwd),
    .cond_n(cond_n), .cond_z(cond_z), .cond_v(cond_v), .cond_c(cond_c),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] got,
                             input logic [3:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive the ID-stage instruction fields.
  task automatic applyStimulus(input logic v, input logic [4:0] rn,
                               input logic rn_u, input logic [4:0] rb,
                               input logic rb_u, input logic [4:0] rd,
                               input logic rw, input logic rm,
                               input logic sf, input logic cbz,
                               input logic br);
    id_valid     = v;
    id_rn        = rn;
    id_rn_used   = rn_u;
    id_rb        = rb;
    id_rb_used   = rb_u;
    id_rd        = rd;
    id_reg_write = rw;
    id_read_mem  = rm;
    id_set_flags = sf;
    id_cbz       = cbz;
    id_br_taken  = br;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Flush the shadow pipeline with empty slots.
  task automatic drain();
    applyNop();
    repeat (3) nextCycle();
  endtask

  function automatic logic [3:0] stall_vec();
    return {pc_en, ifid_en, idex_bubble, ifid_flush};
  endfunction

  initial begin
    reset = 1'b1;
    {ex_n, ex_z, ex_v, ex_c} = 4'b0000;
    applyNop();
    #2;
    checkOutput("reset_ctl", stall_vec(), 4'b1100);
    checkOutput("reset_fwd", {fwd_a, fwd_b}, 4'b0000);
    checkOutput("reset_cbz", {2'b00, cbz_fwd}, 4'b0000);
    checkOutput("reset_flags", {flag_n, flag_z, flag_v, flag_c}, 4'b0000);
    checkOutput("reset_cond", {cond_n, cond_z, cond_v, cond_c}, 4'b0000);
    #1 reset = 1'b0;
    nextCycle();

    // Load-use: LDUR X2,[X1]; ADDS X3,X2,X4
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0);
    #2 checkOutput("lu_ldur_nostall", stall_vec(), 4'b1100);
    nextCycle();
    applyStimulus(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0, 1, 0, 0);
    #2 checkOutput("lu_stall", stall_vec(), 4'b0010);
    nextCycle();
    #2 checkOutput("lu_release", stall_vec(), 4'b1100);
    nextCycle();
    applyNop();
    #2 checkOutput("lu_fwd", {fwd_a, fwd_b}, 4'b1000);
    drain();

    // ALU chain: ADDI X5,X1,#1; EOR X6,X5,X5; AND X7,X0,X5
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0);
    #2 checkOutput("alu_eor_nostall", stall_vec(), 4'b1100);
    nextCycle();
    applyStimulus(1, 5'd0, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0, 0);
    #2 checkOutput("alu_eor_fwd", {fwd_a, fwd_b}, 4'b0101);
    checkOutput("alu_and_nostall", stall_vec(), 4'b1100);
    nextCycle();
    applyNop();
    #2 checkOutput("alu_and_fwd", {fwd_a, fwd_b}, 4'b0010);
    drain();

    // LDUR X1; CBZ X1 -> two stall cycles, then MEM/WB forward
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd1, 1, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd0, 0, 5'd1, 1, 5'd0, 0, 0, 0, 1, 0);
    #2 checkOutput("cbzld_stall1", stall_vec(), 4'b0010);
    nextCycle();
    #2 checkOutput("cbzld_stall2", stall_vec(), 4'b0010);
    nextCycle();
    #2 checkOutput("cbzld_go", stall_vec(), 4'b1100);
    checkOutput("cbzld_fwd", {2'b00, cbz_fwd}, 4'b0010);
    drain();

    // ADDI X1; CBZ X1 -> one stall cycle, then EX/MEM forward
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd1, 1, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd0, 0, 5'd1, 1, 5'd0, 0, 0, 0, 1, 0);
    #2 checkOutput("cbzalu_stall", stall_vec(), 4'b0010);
    nextCycle();
    #2 checkOutput("cbzalu_go", stall_vec(), 4'b1100);
    checkOutput("cbzalu_fwd", {2'b00, cbz_fwd}, 4'b0001);
    drain();

    // Zero register: LDUR X31,[X1]; ADDS X5,X31,X31
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd31, 1, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd31, 1, 5'd31, 1, 5'd5, 1, 0, 1, 0, 0);
    #2 checkOutput("xzr_nostall", stall_vec(), 4'b1100);
    nextCycle();
    applyNop();
    #2 checkOutput("xzr_fwd", {fwd_a, fwd_b}, 4'b0000);
    drain();

    // Flag bypass: SUBS X9,X1,X2 in EX, B.LT in ID
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0, 0);
    nextCycle();
    {ex_n, ex_z, ex_v, ex_c} = 4'b1001;
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    #2 checkOutput("flag_cond_bypass", {cond_n, cond_z, cond_v, cond_c}, 4'b1001);
    checkOutput("flag_reg_before", {flag_n, flag_z, flag_v, flag_c}, 4'b0000);
    checkOutput("flag_flush", stall_vec(), 4'b1101);
    nextCycle();
    {ex_n, ex_z, ex_v, ex_c} = 4'b0110;
    applyNop();
    #2 checkOutput("flag_reg_after", {flag_n, flag_z, flag_v, flag_c}, 4'b1001);
    checkOutput("flag_cond_reg", {cond_n, cond_z, cond_v, cond_c}, 4'b1001);
    {ex_n, ex_z, ex_v, ex_c} = 4'b0000;
    drain();

    // Reset while a load-use stall is active
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0, 1, 0, 0);
    #2 checkOutput("rst_pre_stall", stall_vec(), 4'b0010);
    reset = 1'b1;
    #1 checkOutput("rst_async_ctl", stall_vec(), 4'b1100);
    checkOutput("rst_async_flags", {flag_n, flag_z, flag_v, flag_c}, 4'b0000);
    checkOutput("rst_async_fwd", {fwd_a, fwd_b}, 4'b0000);
    #1 reset = 1'b0;
    #1 checkOutput("rst_release_ctl", stall_vec(), 4'b1100);
    nextCycle();
    applyNop();
    #2 checkOutput("rst_post_fwd", {fwd_a, fwd_b}, 4'b0000);
    checkOutput("rst_post_ctl", stall_vec(), 4'b1100);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline scheduler for the 5-stage LEGv8 core (IF, ID, EX, MEM, WB).
- Keeps its own shadow of the destination info held in ID/EX, EX/MEM and MEM/WB, and generates these controls:
  - load-use and CBZ stalls;
  - registered EX forwarding selects;
  - the ID-stage CBZ forward select;
  - IF/ID flush on a taken branch.
- Owns the N/Z/V/C flag register and bypasses flags produced in EX to the B.LT condition logic in ID.

Parameters:
- REG_W, 5, register address width.
- ZERO_REG, 31, register index that never creates a hazard (XZR).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn  in  REG_W  first source register.
- id_rn_used  in  1  instruction reads Rn.
- id_rb  in  REG_W  second source register (Rm or Rd, per Reg2Loc).
- id_rb_used  in  1  instruction reads the second source.
- id_rd  in  REG_W  destination register.
- id_reg_write  in  1  RegWrite.
- id_read_mem  in  1  load (LDUR).
- id_set_flags  in  1  instruction writes flags (ADDS/SUBS).
- id_cbz  in  1  CBZ in ID; reads id_rb in ID.
- id_br_taken  in  1  BrTaken from the decoder (already uses the cond_* outputs).
- ex_n, ex_z, ex_v, ex_c  in  1 each  ALU flags of the instruction in EX.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP (all write enables 0) into ID/EX.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
- cbz_fwd  out  2  ID CBZ operand select, same encoding as fwd_a/fwd_b.
- cond_n, cond_z, cond_v, cond_c  out  1 each  flags presented to the decoder.
- flag_n, flag_z, flag_v, flag_c  out  1 each  architectural flag register.

Behaviour:
- Reset (asynchronous, immediate):
  - all shadow stage entries invalid;
  - flag register 0;
  - fwd_a/fwd_b = 00;
  - combinational outputs follow from this state: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, cbz_fwd=00, cond_* = 0.
  - Reset mid-stall or mid-flush drops all shadow state; there is no replay.
- Shadow stages:
  - Each stage holds {valid, rd, reg_write, read_mem, set_flags}.
  - Each clock: EX ← ID (invalid if idex_bubble or !id_valid), MEM ← EX, WB ← MEM.
  - An entry whose rd equals ZERO_REG is stored with reg_write forced to 0.
- Match definition: stage S matches a source register r when S.valid, S.reg_write, S.rd == r, r != ZERO_REG, and the corresponding *_used input is 1. For CBZ, the source is id_rb and it counts as used.
- Load-use stall: if id_valid and EX is a load (read_mem) that matches id_rn or id_rb, then:
  - stall = 1;
  - pc_en = 0, ifid_en = 0, idex_bubble = 1;
  - stall lasts exactly 1 cycle per load.
- CBZ stall: if id_cbz, stall = 1 when either:
  - EX matches id_rb (any instruction); or
  - MEM is a load that matches id_rb.
  - A CBZ behind a load to the same register therefore stalls 2 cycles.
- cbz_fwd (combinational):
  - 01 if MEM matches id_rb and MEM is not a load;
  - else 10 if WB matches id_rb;
  - else 00.
- EX forwarding, computed from ID-time state and registered into fwd_a/fwd_b on the ID→EX transfer:
  - 01 if the current EX entry matches (the producer will be in MEM);
  - else 10 if the current MEM entry matches;
  - else 00.
  - EX has priority over MEM.
  - A producer currently in WB needs no forward; the regfile writes in the first half-cycle.
  - On a bubble, register 00.
- Branch flush: ifid_flush = id_valid & id_br_taken & !stall.
  - Stall has priority: a branch in ID during a stall is not acted on; the decoder re-evaluates it next cycle with updated bypasses.
  - Flush does not deassert pc_en (the PC loads the target).
- Flags:
  - On a clock with EX.valid & EX.set_flags, flag_* ← ex_*.
  - cond_* = ex_* when EX.valid & EX.set_flags, else flag_*. This gives back-to-back SUBS→B.LT without a stall.
- Simultaneous stall conditions: OR them; the outputs are identical to a single stall.

Test Plan:
- Load-use stall: LDUR X2,[X1,#0] then ADDS X3,X2,X4 → exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; ADDS enters EX with fwd_a=10.
- ALU chain: ADDI X5,X1,#1; EOR X6,X5,X5; AND X7,X0,X5 → EOR in EX with fwd_a=fwd_b=01; AND in EX with fwd_b=10; no stall.
- CBZ after a load:
  - LDUR X1; CBZ X1 → 2 stall cycles, then cbz_fwd=10.
  - ADDI X1; CBZ X1 → 1 stall cycle, then cbz_fwd=01.
- Zero register: LDUR X31,[X1,#0]; ADDS X5,X31,X31 → no stall; fwd_a=fwd_b=00.
- Flag bypass: SUBS in EX with ex_n=1, ex_v=0, B.LT in ID → cond_n=1 in the same cycle; decoder id_br_taken=1 gives ifid_flush=1; next cycle flag_n=1, flag_v=0.
- Reset during a stall: assert reset while idex_bubble=1 → outputs return to reset values immediately without a clock edge; flags read 0000; no stall after release.
